bcd_code_converter: RTL and testbench

Multi-digit, digit-serial BCD code converter with selectable source and destination codes. It is the parametrised successor to the team's single-digit Excess-3→2421 converter. It accepts a word of DIGITS packed 4-bit BCD digits over a valid/ready handshake and converts one digit per clock. It then presents the converted word, plus a per-digit invalid-code mask, on a registered valid/ready output. It sits between code-producing datapath stages and any consumer that needs a different BCD weighting.

---
 rtl/bcd_code_converter.sv | 238 +++++++++++++++++++++++
 tb/tb_bcd_code_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_code_converter.sv
// ---------------------------------------------------------------------------
// bcd_code_converter
//
// Digit-serial BCD code converter. A word of DIGITS packed 4-bit digits is
// accepted over a valid/ready handshake. The converter translates one digit
// per clock from the source code (in_mode) to the destination code
// (out_mode). It then holds the converted word and a per-digit illegal-code
// mask on a registered valid/ready output until the consumer takes it.
//
// Code encoding for in_mode / out_mode:
//   0 = 8421, 1 = Excess-3, 2 = 2421, 3 = treated as 8421.
//
// Build option:
//   BCD_CONV_ERR_CHECK_EN - when defined, out_err flags source digits that
//                           are not legal in the source code. When undefined,
//                           out_err is tied to zero and no detection logic is
//                           built. In both builds an illegal digit converts
//                           as value 0, so out_data is the same either way.
// ---------------------------------------------------------------------------
module bcd_code_converter #(
  parameter int DIGITS = 4  // legal range 1..16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [1:0]            in_mode,
  input  logic [1:0]            out_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  busy
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_8421 = 2'd0;
  localparam logic [1:0] MODE_XS3  = 2'd1;
  localparam logic [1:0] MODE_2421 = 2'd2;

  // -------------------------------------------------------------------------
  // Code tables
  // -------------------------------------------------------------------------

  // Source code to value 0..9. Illegal codes map to 0, so they emerge as the
  // destination code for zero. Mode 3 and 8421 share the default arm.
  function automatic logic [3:0] decode_digit(input logic [1:0] mode,
                                              input logic [3:0] code);
    logic [3:0] value;
    value = 4'd0;
    case (mode)
      MODE_XS3: begin
        if (code >= 4'd3 && code <= 4'd12) value = code - 4'd3;
      end
      MODE_2421: begin
        if (code <= 4'd7)       value = code;
        else if (code == 4'hE)  value = 4'd8;
        else if (code == 4'hF)  value = 4'd9;
      end
      default: begin
        if (code <= 4'd9) value = code;
      end
    endcase
    return value;
  endfunction

  // Value 0..9 to destination code. Inputs are always 0..9 because they come
  // from decode_digit.
  function automatic logic [3:0] encode_digit(input logic [1:0] mode,
                                              input logic [3:0] value);
    logic [3:0] code;
    case (mode)
      MODE_XS3:  code = value + 4'd3;
      MODE_2421: begin
        if (value == 4'd8)      code = 4'hE;
        else if (value == 4'd9) code = 4'hF;
        else                    code = value;
      end
      default:   code = value;
    endcase
    return code;
  endfunction

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     src_q;        // word captured at accept
  logic [1:0]       in_mode_q;    // modes captured at accept
  logic [1:0]       out_mode_q;
  logic [W-1:0]     out_data_q;   // output shadow, one digit written per CONV cycle

  logic             accept;
  logic             conv_active;
  logic [3:0]       src_digit;
  logic [3:0]       dst_code;
  logic [DIGITS-1:0] digit_we;

  // Registered-state decodes drive every handshake output directly, so the
  // outputs are glitch-free and a reset clears them without waiting for a clock.
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign out_data    = out_data_q;

  assign accept      = in_valid && in_ready;
  assign conv_active = (state_q == ST_CONV);

  // Next-state and digit-counter logic for the IDLE -> CONV -> DONE sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CONV;
          cnt_d   = '0;
        end
      end
      ST_CONV: begin
        // The counter stops on the last digit instead of wrapping. It is
        // cleared again at the next accept.
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the digit addressed by the counter and generate one-hot write enables.
  always_comb begin
    src_digit = '0;
    digit_we  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        src_digit   = src_q[4*i +: 4];
        digit_we[i] = conv_active;
      end
    end
  end

  assign dst_code = encode_digit(out_mode_q, decode_digit(in_mode_q, src_digit));

  // Control state: FSM state and digit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its inputs as they were before the edge.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the source word and both modes on accept. They stay frozen until
  // the next accept, so input changes mid-word have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      in_mode_q  <= MODE_8421;
      out_mode_q <= MODE_8421;
    end else if (accept) begin
      src_q      <= in_data;
      in_mode_q  <= in_mode;
      out_mode_q <= out_mode;
    end
  end

  // Write each converted digit into the output shadow during CONV. Nothing
  // is written in DONE, so the presented word stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this wide output register is reset on purpose because out_data must
    // read zero after reset. Storage with no defined reset value can stay
    // unreset.
    if (!rst_n) begin
      out_data_q <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_we[i]) out_data_q[4*i +: 4] <= dst_code;
      end
    end
  end

`ifdef BCD_CONV_ERR_CHECK_EN
  // -------------------------------------------------------------------------
  // Illegal source-code detection
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] err_q;
  logic              src_illegal;

  // Flag codes outside the source table. Mode 3 is checked as 8421.
  always_comb begin
    case (in_mode_q)
      MODE_XS3:  src_illegal = (src_digit < 4'd3) || (src_digit > 4'd12);
      MODE_2421: src_illegal = (src_digit >= 4'h8) && (src_digit <= 4'hD);
      default:   src_illegal = (src_digit > 4'd9);
    endcase
  end

  // Clear the mask on accept, then record one bit per converted digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (accept) begin
      err_q <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_we[i]) err_q[i] <= src_illegal;
      end
    end
  end

  assign out_err = err_q;
`else
  assign out_err = '0;
`endif

endmodule

// File: tb/tb_bcd_code_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_code_converter
//
// Scoreboard bench for bcd_code_converter with DIGITS = 4. Each word is
// modelled when the DUT accepts it, and the expected result is queued. The
// result is popped and compared at the clock edge where the output transfer
// takes place. Inputs change 1 ns after the rising edge and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_code_converter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0]      data;
    logic [DIGITS-1:0] err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [1:0]        in_mode;
  logic [1:0]        out_mode;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [DIGITS-1:0] out_err;
  logic              busy;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pop_cyc  = 0;

  bcd_code_converter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_mode  (out_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Code of value v in the given mode (mode 3 behaves as 8421).
  function automatic logic [3:0] code_of(input logic [1:0] m, input int v);
    case (m)
      2'd1:    return 4'(v + 3);
      2'd2:    return (v == 8) ? 4'hE : (v == 9) ? 4'hF : 4'(v);
      default: return 4'(v);
    endcase
  endfunction

  // Reference model: the source table is searched to find each digit's value.
  function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] im, input logic [1:0] om);
    exp_t r;
    r.data = '0;
    r.err  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      logic [3:0] c;
      int         val;
      bit         found;
      c     = d[4*k +: 4];
      val   = 0;
      found = 1'b0;
      for (int v = 0; v < 10; v++) begin
        if (code_of(im, v) == c) begin
          val   = v;
          found = 1'b1;
        end
      end
      r.data[4*k +: 4] = code_of(om, val);
`ifdef BCD_CONV_ERR_CHECK_EN
      r.err[k] = !found;
`endif
    end
    return r;
  endfunction

  // Output monitor: a transfer takes place at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_val("out_data", 32'(out_data), 32'(e.data));
        check_val("out_err", 32'(out_err), 32'(e.err));
      end
      pop_cyc = cyc;
    end
  end

  // Drive one word and wait for it to be accepted. The task is entered just
  // after a rising edge and returns 1 ns after the accepting edge. acc is the
  // cycle number of that edge.
  task automatic send_word(input logic [W-1:0] d, input logic [1:0] im,
                           input logic [1:0] om, output int acc);
    in_data  = d;
    in_mode  = im;
    out_mode = om;
    in_valid = 1'b1;
    acc      = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d, im, om));
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc < 0) check_val("accept_timeout", 32'd1, 32'd0);
  endtask

  // Wait until every queued word has been delivered.
  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_val(tag, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   acc, a0, a1, a2, lat;
    bit   seen;
    exp_t dummy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    out_mode  = 2'd0;
    out_ready = 1'b1;

    // Reset values
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Excess-3 -> 2421, latency from accept to out_valid
    send_word(16'h3456, 2'd1, 2'd2, acc);
    in_data = 16'hFFFF;   // changing the inputs after accept must have no effect
    in_mode = 2'd0;
    out_mode = 2'd0;
    @(negedge clk);
    check_val("conv_busy", 32'(busy), 32'd1);
    check_val("conv_in_ready", 32'(in_ready), 32'd0);
    check_val("conv_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    lat  = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc - acc;
        break;
      end
    end
    check_val("latency", 32'(lat), 32'd4);
    check_val("out_valid_seen", 32'(seen), 32'd1);
    wait_drain("drain_t2");

    // Round trip between Excess-3 and 2421
    send_word(16'hCBA9, 2'd1, 2'd2, acc);
    wait_drain("drain_t3a");
    send_word(16'hFE76, 2'd2, 2'd1, acc);
    wait_drain("drain_t3b");

    // Illegal 8421 digit -> destination code for zero
    send_word(16'h00A0, 2'd0, 2'd1, acc);
    wait_drain("drain_t4");
    send_word(16'h2B80, 2'd2, 2'd3, acc);   // 2421 illegal digits, mode 3 out
    wait_drain("drain_t4b");

    // Backpressure in DONE while a new word is offered
    out_ready = 1'b0;
    send_word(16'h1234, 2'd0, 2'd0, acc);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("bp_valid_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h9876;
    in_mode  = 2'd0;
    out_mode = 2'd1;
    repeat (5) begin
      @(negedge clk);
      check_val("bp_out_data", 32'(out_data), 32'h1234);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(16'h9876, 2'd0, 2'd1, acc);
    check_val("bp_accept_after_xfer", 32'(acc - pop_cyc), 32'd2);
    wait_drain("drain_t5");

    // Reset during the second CONV cycle
    send_word(16'h345F, 2'd1, 2'd0, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_out_err", 32'(out_err), 32'd0);
    check_val("midrst_out_data", 32'(out_data), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    dummy = sb.pop_back();   // the word in flight is discarded
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(16'h3456, 2'd1, 2'd2, acc);
    wait_drain("drain_t6");

    // Back-to-back words, one every DIGITS+2 cycles
    out_ready = 1'b1;
    send_word(W'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a0);
    send_word(W'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a1);
    send_word(W'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a2);
    check_val("b2b_rate_1", 32'(a1 - a0), 32'(DIGITS + 2));
    check_val("b2b_rate_2", 32'(a2 - a1), 32'(DIGITS + 2));
    for (int k = 0; k < 6; k++) begin
      send_word(W'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), acc);
    end
    wait_drain("drain_t7");
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
